// File: rtl/pipe_mux_rr.sv
// N-to-1 channel multiplexer with fixed-select or round-robin arbitration feeding
// a single registered output entry. Define PIPE_MUX_PARITY_EN to add the out_par output.
module pipe_mux_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
`ifdef PIPE_MUX_PARITY_EN
  output logic           out_par,
`endif
  input  logic           out_ready
);

  // Handshake: a word moves on any cycle where valid and ready are both high at
  // the rising edge. in_ready never depends on the in_valid of the same channel
  // in fixed mode; in round-robin mode it follows the granted valid.

  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [SW-1:0] ptr;
  logic          can_accept;
  logic          sel_ok;
  logic          rr_found;
  logic [SW-1:0] rr_grant;
  int            rr_idx;
  logic [W-1:0]  sel_data;
  logic          in_xfer;

  assign can_accept = !out_valid || out_ready;
  assign sel_ok     = ({1'b0, sel} < N_EXT);

  // First valid channel at or after ptr, wrapping modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = 0;
    for (int i = 0; i < N; i++) begin
      rr_idx = (int'(ptr) + i) % N;
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = SW'(rr_idx);
      end
    end
  end

  // At most one ready bit; all low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (rst_n) begin
      if (mode) begin
        if (rr_found) in_ready[rr_grant] = can_accept;
      end else if (sel_ok) begin
        in_ready[sel] = can_accept;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (in_ready[k]) sel_data = in_data[k*W +: W];
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
    end else if (out_valid && out_ready) begin
      // Data is kept as-is; only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

`ifdef PIPE_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (in_xfer) begin
      out_par <= ^sel_data;
    end
  end
`endif

  // ptr only advances on a round-robin grant that actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (mode && in_xfer) begin
      if (rr_grant == LAST_IDX) ptr <= '0;
      else                      ptr <= rr_grant + SW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_mux_rr.sv
// Directed bench for pipe_mux_rr (N=4, W=8): vector table plus hand sequences
// for stall, asynchronous reset and (when PIPE_MUX_PARITY_EN is defined) parity.
module tb_pipe_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
`ifdef PIPE_MUX_PARITY_EN
  logic           out_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef PIPE_MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [31:0]  in_data;
    logic         out_ready;
    logic [3:0]   exp_in_ready;
    logic         exp_out_valid;
    logic [7:0]   exp_out_data;
  } vec_t;

  localparam logic [31:0] D = 32'h3CA5_2110;  // ch3=3C ch2=A5 ch1=21 ch0=10

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input logic r);
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Drive on negedge, check ready before posedge, check outputs after posedge.
  task automatic step(input string name, input logic [3:0] exp_rdy,
                      input logic exp_ov, input logic [7:0] exp_od);
    #1;
    chk({name, ".in_ready"}, {28'b0, in_ready}, {28'b0, exp_rdy});
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) chk({name, ".out_data"}, {24'b0, out_data}, {24'b0, exp_od});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'hA5};
    vecs[1]  = '{1'b0, 2'd2, 4'b0000, D, 1'b1, 4'b0100, 1'b0, 8'hA5};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'h21};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'hA5};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h3C};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10};
    vecs[7]  = '{1'b1, 2'd0, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h10};
    vecs[8]  = '{1'b1, 2'd0, 4'b0010, D, 1'b1, 4'b0010, 1'b1, 8'h21};
    vecs[9]  = '{1'b1, 2'd0, 4'b0011, D, 1'b1, 4'b0001, 1'b1, 8'h10};
    vecs[10] = '{1'b1, 2'd0, 4'b0011, D, 1'b1, 4'b0010, 1'b1, 8'h21};
    vecs[11] = '{1'b1, 2'd0, 4'b1000, D, 1'b0, 4'b0000, 1'b1, 8'h21};
    vecs[12] = '{1'b1, 2'd0, 4'b1000, D, 1'b1, 4'b1000, 1'b1, 8'h3C};
    vecs[13] = '{1'b0, 2'd1, 4'b0000, D, 1'b0, 4'b0000, 1'b1, 8'h3C};

    // reset state
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b1111, D, 1'b1);
    #12;
    chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset.out_data", {24'b0, out_data}, 32'd0);
    chk("reset.in_ready", {28'b0, in_ready}, 32'd0);
`ifdef PIPE_MUX_PARITY_EN
    chk("reset.out_par", {31'b0, out_par}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].sel, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      step($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid, vecs[i].exp_out_data);
    end

    // stall: 0x3C held for 5 cycles with out_ready low
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 4'b1111, D, 1'b0);
      step($sformatf("stall%0d", c), 4'b0000, 1'b1, 8'h3C);
    end
    // release: new word taken the same cycle; RR grant 2 moves ptr to 3
    @(negedge clk);
    drive(1'b1, 2'd0, 4'b0100, D, 1'b1);
    step("stall_release", 4'b0100, 1'b1, 8'hA5);

    // async reset pulse between edges while a word is held
    @(negedge clk);
    drive(1'b0, 2'd0, 4'b1111, D, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("pulse.out_valid", {31'b0, out_valid}, 32'd0);
    chk("pulse.out_data", {24'b0, out_data}, 32'd0);
    chk("pulse.in_ready", {28'b0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 4'b1111, D, 1'b1);
    // ptr cleared: grant is channel 0, not channel 3
    step("post_reset", 4'b0001, 1'b1, 8'h10);

`ifdef PIPE_MUX_PARITY_EN
    @(negedge clk);
    drive(1'b0, 2'd0, 4'b1111, 32'h0000_0307, 1'b1);
    step("par07", 4'b0001, 1'b1, 8'h07);
    chk("par07.out_par", {31'b0, out_par}, 32'd1);
    @(negedge clk);
    drive(1'b0, 2'd1, 4'b1111, 32'h0000_0307, 1'b1);
    step("par03", 4'b0010, 1'b1, 8'h03);
    chk("par03.out_par", {31'b0, out_par}, 32'd0);
`endif

    @(negedge clk);
    drive(1'b0, 2'd0, 4'b0000, D, 1'b1);
    step("drain", 4'b0001, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
